// File: rtl/dram_stream_reader_pkg.sv
// dram_stream_reader_pkg: shared FSM encodings and address-width helper for the dram read engine
package dram_stream_reader_pkg;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;
  function automatic int addr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/dram_stream_reader.sv
// dram_stream_reader: streams a burst from a dram async read port onto an AXI4-Stream master
module dram_stream_reader
  import dram_stream_reader_pkg::*;
#(
  parameter int FIFO_SIZE = 1024,
  parameter int BIT_WIDTH = 32,
  localparam int AW = addr_width(FIFO_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW-1:0]        length,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        dram_raddr,
  input  logic [BIT_WIDTH-1:0] dram_dout,
  output logic [BIT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);
  localparam logic [AW-1:0] DEPTH = AW'(FIFO_SIZE);
  localparam logic [AW-1:0] LAST  = AW'(FIFO_SIZE - 1);
  logic [0:0]    state;
  logic [AW-1:0] remaining;
  logic          ld, hs, bad;
  assign hs  = m_axis_tvalid && m_axis_tready;
  assign ld  = (remaining != '0) && (!m_axis_tvalid || m_axis_tready);
  assign bad = (start_addr >= DEPTH) || (length > DEPTH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      dram_raddr    <= '0;
      remaining     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          if (bad) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (length == '0) begin
            done <= 1'b1;
          end else begin
            state      <= ST_STREAM;
            dram_raddr <= start_addr;
            remaining  <= length;
            busy       <= 1'b1;
          end
        end
      end else if (hs && m_axis_tlast) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        busy          <= 1'b0;
        done          <= 1'b1;
        state         <= ST_IDLE;
      end else if (ld) begin
        // dram_dout is combinational from dram_raddr, so the word is captured the same cycle
        m_axis_tdata  <= dram_dout;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (remaining == AW'(1));
        remaining     <= remaining - AW'(1);
        dram_raddr    <= (dram_raddr == LAST) ? '0 : dram_raddr + AW'(1);
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dram_stream_reader.sv
// tb_dram_stream_reader: scoreboard bench for dram_stream_reader with a 16-word RAM model
module tb_dram_stream_reader;
  localparam int FS = 16;
  localparam int BW = 32;
  localparam int AW = $clog2(FS) + 1;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, tready = 1'b1;
  logic [AW-1:0] start_addr = '0, length = '0, raddr;
  logic          busy, done, err, tvalid, tlast;
  logic [BW-1:0] dout, tdata;
  logic [BW-1:0] mem [FS];
  assign dout = mem[raddr[3:0]];
  always #5 clk = ~clk;
  dram_stream_reader #(.FIFO_SIZE(FS), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .err(err), .dram_raddr(raddr), .dram_dout(dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
  );
  int checks = 0, passes = 0, cyc = 0, hs_count = 0, last_hs_cyc = 0;
  logic [BW:0] exp_beats [$];
  logic [1:0]  exp_done [$];
  logic [BW:0] e;
  logic [1:0]  d;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [BW-1:0] pd = '0;
  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(posedge clk) cyc++;
  // Monitor: pops beat and completion expectations, and checks stall stability
  always @(negedge clk) begin
    if (pv === 1'b1 && !pr && rst_n) begin
      check("hold_valid", tvalid, 1);
      check("hold_data", tdata, pd);
      check("hold_last", tlast, pl);
    end
    if (tvalid === 1'b1 && tready) begin
      if (exp_beats.size() == 0) check("extra_beat", tvalid, 0);
      else begin
        e = exp_beats.pop_front();
        check("beat_data", tdata, e[BW-1:0]);
        check("beat_last", tlast, e[BW]);
        hs_count++;
        if (tlast) last_hs_cyc = cyc;
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) check("extra_done", done, 0);
      else begin
        d = exp_done.pop_front();
        check("done_err", err, d[1]);
        if (d[0]) check("done_latency", cyc, last_hs_cyc + 1);
      end
    end
    pv = tvalid; pr = tready; pd = tdata; pl = tlast;
  end
  task automatic issue(input int a, input int l, input bit bad);
    for (int i = 0; i < l && !bad; i++) exp_beats.push_back({1'(i == l - 1), mem[(a + i) % FS]});
    exp_done.push_back({bad, 1'(!bad && l != 0)});
    start_addr = AW'(a);
    length = AW'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({name, "_timeout"}, done, 1);
  endtask
  initial begin
    int base, n;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < FS; i++) mem[i] = BW'(i + 100);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_raddr", raddr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4, 4, 0); wait_done("basic");
    fork
      issue(0, 3, 0);
      begin
        foreach (pat[i]) begin
          tready = pat[i];
          @(posedge clk); #1;
        end
        tready = 1'b1;
      end
    join
    wait_done("backpressure");
    issue(14, 4, 0); wait_done("wrap");
    issue(15, 3, 0); wait_done("wrap_edge");
    issue(5, 16, 0); wait_done("full");
    issue(0, 0, 0); wait_done("len_zero");
    issue(16, 2, 1); wait_done("bad_addr");
    issue(0, 17, 1); wait_done("bad_len");
    issue(2, 6, 0);
    repeat (2) @(posedge clk);
    #1;
    start_addr = AW'(9); length = AW'(3); start = 1'b1;
    check("busy_mid", busy, 1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore");
    @(posedge clk); #1;
    base = hs_count;
    for (int i = 0; i < 8; i++) exp_beats.push_back({1'(i == 7), mem[i]});
    start_addr = '0; length = AW'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (hs_count < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("abort_timeout", tvalid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_tvalid", tvalid, 0);
    check("abort_busy", busy, 0);
    exp_beats.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(1, 2, 0); wait_done("b2b_first");
    issue(6, 3, 0);
    check("b2b_accept_tvalid", tvalid, 0);
    check("b2b_accept_busy", busy, 1);
    @(posedge clk); #1;
    check("b2b_first_tvalid", tvalid, 1);
    wait_done("b2b_second");
    repeat (3) @(posedge clk);
    #1;
    check("beats_left", exp_beats.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
